// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS CPU bus arbiter.
package mips_bus_pkg;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  // Externally visible owner code for an arbiter state.
  function automatic logic [1:0] grant_of(arb_state_t s);
    case (s)
      GNT_I:   grant_of = GRANT_I;
      GNT_D:   grant_of = GRANT_D;
      default: grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mips_bus_watchdog.sv
// Stall watchdog: counts consecutive slave-stalled cycles within one grant
// and raises a sticky error flag once the count reaches WAIT_LIMIT.
// WAIT_LIMIT must fit in CNT_W bits (WAIT_LIMIT < 2**CNT_W).
module mips_bus_watchdog #(
  parameter int WAIT_LIMIT = 1024,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic stall,
  output logic error
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;

  // Saturating stall counter; a clear (state change) always wins.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (stall && (cnt_q != LIMIT))
      cnt_d = cnt_q + 1'b1;
    error_d = error_q | (cnt_d == LIMIT);
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master (fetch I / load-store D) arbiter for a single Avalon-style
// memory port, with a stall watchdog.
// Optional macro MIPS_ARB_ROUND_ROBIN_EN: tie-break in IDLE alternates
// instead of the default fixed D-over-I priority.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int WAIT_LIMIT = 1024,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BUS_AW-1:0]  i_address,
  input  logic               i_read,
  output logic               i_waitrequest,
  output logic [BUS_DW-1:0]  i_readdata,
  input  logic [BUS_AW-1:0]  d_address,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [BUS_DW-1:0]  d_writedata,
  input  logic [BUS_BEW-1:0] d_byteenable,
  output logic               d_waitrequest,
  output logic [BUS_DW-1:0]  d_readdata,
  output logic [BUS_AW-1:0]  address,
  output logic               read,
  output logic               write,
  output logic [BUS_DW-1:0]  writedata,
  output logic [BUS_BEW-1:0] byteenable,
  input  logic               waitrequest,
  input  logic [BUS_DW-1:0]  readdata,
  output logic [1:0]         grant,
  output logic               bus_error
);

  arb_state_t state_q, state_d;
  logic       req_i, req_d;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
  // 1 when the last grant issued out of IDLE went to D.
  logic last_d_q, last_d_d;
`endif

  // Next-state: registered arbitration from IDLE, direct hand-over on completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
`ifdef MIPS_ARB_ROUND_ROBIN_EN
        if (req_i && req_d) state_d = last_d_q ? GNT_I : GNT_D;
        else if (req_d)     state_d = GNT_D;
        else if (req_i)     state_d = GNT_I;
`else
        if (req_d)      state_d = GNT_D;
        else if (req_i) state_d = GNT_I;
`endif
      end
      GNT_I: begin
        if (!req_i)            state_d = IDLE;  // abandoned request
        else if (!waitrequest) state_d = req_d ? GNT_D : IDLE;
      end
      GNT_D: begin
        if (!req_d)            state_d = IDLE;  // abandoned request
        else if (!waitrequest) state_d = req_i ? GNT_I : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MIPS_ARB_ROUND_ROBIN_EN
  // Only IDLE grants move the tie-break pointer; hand-overs on completion don't.
  always_comb begin
    last_d_d = last_d_q;
    if ((state_q == IDLE) && (state_d != IDLE))
      last_d_d = (state_d == GNT_D);
  end
`endif

  // State register; reset drops the bus immediately since outputs decode state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  // Slave-side mux and master stalls; a dropped request gates its own strobe.
  always_comb begin
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = '0;
    byteenable    = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    grant         = grant_of(state_q);
    unique case (state_q)
      GNT_I: begin
        address       = i_address;
        read          = i_read;
        byteenable    = '1;
        i_waitrequest = waitrequest;
      end
      GNT_D: begin
        address       = d_address;
        read          = d_read & ~d_write;  // write wins on a read+write
        write         = d_write;
        writedata     = d_writedata;
        byteenable    = d_byteenable;
        d_waitrequest = waitrequest;
      end
      default: ;
    endcase
  end

  assign i_readdata = readdata;
  assign d_readdata = readdata;

  mips_bus_watchdog #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_d != state_q),
    .stall ((state_q != IDLE) && waitrequest),
    .error (bus_error)
  );

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios plus a
// randomized two-master run scored against a word-level memory model.
module tb_mips_bus_arbiter;
  import mips_bus_pkg::*;

  logic        clk, rst_n;
  logic [31:0] i_address, i_readdata, d_address, d_writedata, d_readdata;
  logic [31:0] address, writedata, readdata;
  logic        i_read, i_waitrequest, d_read, d_write, d_waitrequest;
  logic        read, write, waitrequest, bus_error;
  logic [3:0]  d_byteenable, byteenable;
  logic [1:0]  grant;

  int n_chk = 0;
  int n_fail = 0;

  // RAM slave: 64 words, waitrequest held for ram_lat cycles per access.
  logic [31:0] mem [64];
  int          ram_lat;
  bit          ram_stall;
  int          wcnt;

  assign waitrequest = ram_stall || (wcnt < ram_lat);
  assign readdata    = mem[address[7:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0;
      for (int k = 0; k < 64; k++) mem[k] <= 32'hA500_0000 + 32'(k) * 32'h0001_0101;
    end else if (!(read || write)) begin
      wcnt <= 0;
    end else if (waitrequest) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
      if (write)
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) mem[address[7:2]][8*b +: 8] <= writedata[8*b +: 8];
    end
  end

  mips_bus_arbiter #(.WAIT_LIMIT(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .address(address), .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .grant(grant), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_chk++; if ({read, write} !== 2'b00) begin n_fail++; $display("FAIL reset_rw: got %b want 00", {read, write}); end
    n_chk++; if ({address, writedata, byteenable} !== 68'h0) begin n_fail++; $display("FAIL reset_bus: addr %h wdata %h be %h want 0", address, writedata, byteenable); end
    n_chk++; if ({i_waitrequest, d_waitrequest} !== 2'b11) begin n_fail++; $display("FAIL reset_wait: got %b want 11", {i_waitrequest, d_waitrequest}); end
    n_chk++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL reset_bus_error: got %b want 0", bus_error); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    ram_lat = 1;
    i_address = 32'hBFC0_0000;
    i_read = 1'b1;
    #1;
    n_chk++; if (grant !== GRANT_NONE) begin n_fail++; $display("FAIL fetch_arb_cycle: grant %b want 00", grant); end
    tick();
    n_chk++; if (grant !== GRANT_I) begin n_fail++; $display("FAIL fetch_grant: got %b want 01", grant); end
    n_chk++; if ({address, read} !== {32'hBFC0_0000, 1'b1}) begin n_fail++; $display("FAIL fetch_bus: addr %h read %b want bfc00000/1", address, read); end
    n_chk++; if (i_waitrequest !== 1'b1) begin n_fail++; $display("FAIL fetch_wait1: got %b want 1", i_waitrequest); end
    tick();
    n_chk++; if ({i_waitrequest, d_waitrequest} !== 2'b01) begin n_fail++; $display("FAIL fetch_wait0: got %b want 01", {i_waitrequest, d_waitrequest}); end
    n_chk++; if (i_readdata !== 32'hA500_0000) begin n_fail++; $display("FAIL fetch_data: got %h want a5000000", i_readdata); end
    tick();
    i_read = 1'b0;
    n_chk++; if (grant !== GRANT_NONE) begin n_fail++; $display("FAIL fetch_idle: grant %b want 00", grant); end
  endtask

  // Two simultaneous I/D requests; checks the order and that no IDLE cycle separates them.
  task automatic test_ties();
    bit dfirst;
    logic [1:0] g1, g2;
    do_reset();
    ram_lat = 1;
    for (int t = 0; t < 2; t++) begin
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      dfirst = (t == 1);
`else
      dfirst = 1'b1;
`endif
      g1 = dfirst ? GRANT_D : GRANT_I;
      g2 = dfirst ? GRANT_I : GRANT_D;
      i_address = 32'hBFC0_0004; i_read = 1'b1;
      d_address = 32'h0000_1000; d_write = 1'b1; d_read = 1'b0;
      d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
      tick();
      n_chk++; if (grant !== g1) begin n_fail++; $display("FAIL tie%0d_first: grant %b want %b", t, grant, g1); end
      if (dfirst) begin
        n_chk++; if ({address, read, write, writedata, byteenable} !== {32'h1000, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011})
          begin n_fail++; $display("FAIL tie%0d_dbus: addr %h r %b w %b wd %h be %b", t, address, read, write, writedata, byteenable); end
      end else begin
        n_chk++; if ({address, read, write, byteenable} !== {32'hBFC0_0004, 1'b1, 1'b0, 4'hF})
          begin n_fail++; $display("FAIL tie%0d_ibus: addr %h r %b w %b be %b", t, address, read, write, byteenable); end
      end
      tick();
      n_chk++; if ({i_waitrequest, d_waitrequest} !== (dfirst ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL tie%0d_first_done: waits %b", t, {i_waitrequest, d_waitrequest}); end
      if (!dfirst) begin
        n_chk++; if (i_readdata !== 32'hA501_0101) begin n_fail++; $display("FAIL tie%0d_idata: got %h want a5010101", t, i_readdata); end
      end
      tick();
      if (dfirst) d_write = 1'b0; else i_read = 1'b0;
      n_chk++; if (grant !== g2) begin n_fail++; $display("FAIL tie%0d_switch: grant %b want %b", t, grant, g2); end
      tick();
      n_chk++; if ({i_waitrequest, d_waitrequest} !== (dfirst ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL tie%0d_second_done: waits %b", t, {i_waitrequest, d_waitrequest}); end
      if (dfirst) begin
        n_chk++; if (i_readdata !== 32'hA501_0101) begin n_fail++; $display("FAIL tie%0d_idata: got %h want a5010101", t, i_readdata); end
      end
      tick();
      if (dfirst) i_read = 1'b0; else d_write = 1'b0;
      n_chk++; if (grant !== GRANT_NONE) begin n_fail++; $display("FAIL tie%0d_idle: grant %b want 00", t, grant); end
      n_chk++; if (mem[0] !== 32'hA500_BEEF) begin n_fail++; $display("FAIL tie%0d_mem: got %h want a500beef", t, mem[0]); end
    end
  endtask

  task automatic test_rw_both();
    ram_lat = 1;
    d_address = 32'h20; d_read = 1'b1; d_write = 1'b1;
    d_writedata = 32'h1234_5678; d_byteenable = 4'hF;
    tick();
    n_chk++; if ({grant, read, write, address} !== {GRANT_D, 1'b0, 1'b1, 32'h20}) begin n_fail++; $display("FAIL rw_bus: grant %b r %b w %b addr %h", grant, read, write, address); end
    tick();
    n_chk++; if ({d_waitrequest, read} !== 2'b00) begin n_fail++; $display("FAIL rw_done: dwait %b read %b want 00", d_waitrequest, read); end
    tick();
    d_read = 1'b0; d_write = 1'b0;
    n_chk++; if (mem[8] !== 32'h1234_5678) begin n_fail++; $display("FAIL rw_mem: got %h want 12345678", mem[8]); end
  endtask

  task automatic test_watchdog();
    ram_stall = 1'b1;
    d_address = 32'h40; d_read = 1'b1; d_write = 1'b0;
    tick();
    n_chk++; if ({grant, bus_error} !== {GRANT_D, 1'b0}) begin n_fail++; $display("FAIL wd_start: grant %b err %b", grant, bus_error); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_chk++; if (bus_error !== (k == 8)) begin n_fail++; $display("FAIL wd_cycle%0d: err %b want %b", k, bus_error, (k == 8)); end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if ({grant, bus_error} !== {GRANT_D, 1'b1}) begin n_fail++; $display("FAIL wd_sticky: grant %b err %b want 10/1", grant, bus_error); end
    end
  endtask

  // Entered while still stalled in GNT_D from test_watchdog.
  task automatic test_reset_mid();
    bit got;
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if ({read, write, grant} !== 4'b0000) begin n_fail++; $display("FAIL rmid_bus: r %b w %b grant %b want 0", read, write, grant); end
    n_chk++; if ({i_waitrequest, d_waitrequest, bus_error} !== 3'b110) begin n_fail++; $display("FAIL rmid_flags: iw %b dw %b err %b want 110", i_waitrequest, d_waitrequest, bus_error); end
    d_read = 1'b0; ram_stall = 1'b0; ram_lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    i_address = 32'hBFC0_0008; i_read = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (!i_waitrequest) got = 1'b1;
    end
    n_chk++; if (!got) begin n_fail++; $display("FAIL rmid_fetch_timeout: no completion within 10 cycles"); end
    else begin
      n_chk++; if (i_readdata !== 32'hA502_0202) begin n_fail++; $display("FAIL rmid_fetch_data: got %h want a5020202", i_readdata); end
    end
    tick();
    i_read = 1'b0;
  endtask

  // Random traffic from both masters; data checked against a word model.
  task automatic test_random();
    logic [31:0] model [64];
    int   i_age, d_age, n_i, n_d, kind;
    bit   i_done, d_done;
    i_age = 0; d_age = 0; n_i = 0; n_d = 0;
    tick();
    for (int k = 0; k < 64; k++) model[k] = mem[k];
    repeat (600) begin
      @(negedge clk);
      case (grant)
        GRANT_I: begin
          n_chk++; if ({address, read, write, byteenable} !== {i_address, i_read, 1'b0, 4'hF}) begin n_fail++; $display("FAIL rnd_ibus: addr %h r %b w %b be %h", address, read, write, byteenable); end
        end
        GRANT_D: begin
          n_chk++; if ({address, read, write, writedata, byteenable} !== {d_address, d_read & ~d_write, d_write, d_writedata, d_byteenable})
            begin n_fail++; $display("FAIL rnd_dbus: addr %h r %b w %b wd %h be %h", address, read, write, writedata, byteenable); end
        end
        GRANT_NONE: begin
          n_chk++; if ({read, write} !== 2'b00) begin n_fail++; $display("FAIL rnd_idle_bus: r %b w %b", read, write); end
        end
        default: begin
          n_chk++; n_fail++; $display("FAIL rnd_grant: got %b", grant);
        end
      endcase
      n_chk++; if ((!i_waitrequest && grant !== GRANT_I) || (!d_waitrequest && grant !== GRANT_D))
        begin n_fail++; $display("FAIL rnd_wait_owner: iw %b dw %b grant %b", i_waitrequest, d_waitrequest, grant); end
      i_done = i_read && !i_waitrequest;
      d_done = (d_read || d_write) && !d_waitrequest;
      if (i_done) begin
        n_i++;
        n_chk++; if (i_readdata !== model[i_address[7:2]]) begin n_fail++; $display("FAIL rnd_idata: addr %h got %h want %h", i_address, i_readdata, model[i_address[7:2]]); end
      end
      if (d_done) begin
        n_d++;
        if (d_write) begin
          for (int b = 0; b < 4; b++)
            if (d_byteenable[b]) model[d_address[7:2]][8*b +: 8] = d_writedata[8*b +: 8];
        end else begin
          n_chk++; if (d_readdata !== model[d_address[7:2]]) begin n_fail++; $display("FAIL rnd_ddata: addr %h got %h want %h", d_address, d_readdata, model[d_address[7:2]]); end
        end
      end
      i_age = (i_read && !i_done) ? i_age + 1 : 0;
      d_age = ((d_read || d_write) && !d_done) ? d_age + 1 : 0;
      if (i_age > 12 || d_age > 12) begin
        n_chk++; n_fail++; $display("FAIL rnd_starve: i_age %0d d_age %0d", i_age, d_age);
        i_age = 0; d_age = 0;
      end
      tick();
      ram_lat = $urandom_range(0, 2);
      if (!i_read || i_done) begin
        i_read = ($urandom_range(0, 2) != 0);
        i_address = 32'hBFC0_0000 | {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (!(d_read || d_write) || d_done) begin
        kind = $urandom_range(0, 3);
        d_read = (kind == 1) || (kind == 3);
        d_write = (kind >= 2);
        d_address = 32'h0000_1000 | {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        d_writedata = $urandom;
        d_byteenable = 4'($urandom_range(1, 15));
      end
    end
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    n_chk++; if (n_i == 0 || n_d == 0) begin n_fail++; $display("FAIL rnd_activity: fetches %0d data %0d", n_i, n_d); end
    n_chk++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL rnd_bus_error: got %b want 0", bus_error); end
  endtask

  initial begin
    rst_n = 1'b0;
    i_address = '0; i_read = 1'b0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0; d_writedata = '0; d_byteenable = '0;
    ram_lat = 1; ram_stall = 1'b0;
    test_reset();
    test_fetch();
    test_ties();
    test_rw_both();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the single Avalon-style memory port (address/read/write/waitrequest/writedata/byteenable/readdata) between two CPU requesters: instruction fetch (I) and data load/store (D).
- Sits between the mips_cpu_bus internal fetch/LSU units and the external RAM port.
- Lets the CPU overlap fetch and data traffic against RAM models with arbitrary waitrequest latency.
- Also provides a stall watchdog.

Parameters:
- WAIT_LIMIT, 1024, consecutive slave-waitrequest cycles within one grant before bus_error is set.
- CNT_W, 16, watchdog counter width; WAIT_LIMIT must be < 2**CNT_W.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_address  in  32  fetch address
- i_read  in  1  fetch request, held until i_waitrequest=0
- i_waitrequest  out  1  stall to fetch unit
- i_readdata  out  32  fetch data, valid when i_read & !i_waitrequest
- d_address  in  32  data address
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_writedata  in  32  store data
- d_byteenable  in  4  store/load lane enables
- d_waitrequest  out  1  stall to LSU
- d_readdata  out  32  load data, valid when d_read & !d_waitrequest
- address  out  32  to memory
- read  out  1  to memory
- write  out  1  to memory
- writedata  out  32  to memory
- byteenable  out  4  to memory
- waitrequest  in  1  from memory
- readdata  in  32  from memory
- grant  out  2  current owner: 00 none, 01 I, 10 D
- bus_error  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; grant=00; read=write=0; address=writedata=0; byteenable=0.
  - i_waitrequest=d_waitrequest=1; bus_error=0; watchdog counter=0.
- States:
  - IDLE: slave outputs all zero; both master waitrequests=1.
  - GNT_I: slave outputs = {i_address, i_read, write=0, writedata=0, byteenable=4'hF}.
  - GNT_D: slave outputs = {d_address, d_read & !d_write, d_write, d_writedata, d_byteenable}. A simultaneous read+write from D forwards the write only.
- Master request definitions: req_i = i_read; req_d = d_read | d_write.
- Arbitration from IDLE: registered; a request seen in IDLE is granted the following cycle. Minimum latency is 1 arbitration cycle + slave latency. Fixed priority: D beats I.
- In a GNT state:
  - The granted master's waitrequest = slave waitrequest, combinational.
  - The other master's waitrequest = 1.
  - Slave outputs are combinationally muxed from the granted master's inputs.
- Completion: granted request high and waitrequest=0 at a rising edge.
  - If the other master is requesting that cycle: switch directly to its GNT state (no IDLE bubble).
  - Otherwise: go to IDLE.
- A granted master dropping its request without completion (protocol violation): its read/write are gated to 0 that cycle; return to IDLE next edge.
- readdata is broadcast to i_readdata and d_readdata unmodified. Only the granted master sees waitrequest=0.
- Watchdog:
  - Counter clears on every state change.
  - Increments each cycle in a GNT state with waitrequest=1, saturating at WAIT_LIMIT.
  - When it reaches WAIT_LIMIT, bus_error is set and stays set until reset.
  - bus_error does not alter arbitration.
- Reset mid-transaction: immediate IDLE and slave read/write=0; no completion is reported to either master.

Optional Feature:
- Macro: MIPS_ARB_ROUND_ROBIN_EN.
- Defined:
  - IDLE arbitration on simultaneous requests grants the master that was NOT granted last.
  - A last_owner flop resets to D, so I wins the first tie.
  - Switch-on-completion behaviour is unchanged.
- Undefined: fixed D-over-I priority as above; no last_owner flop.

Decomposition:
- Package mips_bus_pkg:
  - arb_state_t enum {IDLE, GNT_I, GNT_D}.
  - GRANT_NONE/GRANT_I/GRANT_D 2-bit constants.
  - BUS_AW=32, BUS_DW=32, BUS_BEW=4.
- Sub-module mips_bus_watchdog (clk, rst_n, clear, stall, error; params WAIT_LIMIT, CNT_W): counter plus sticky flag.
- Muxing and FSM stay in the top module.

Test Plan:
- Lone fetch, 1-cycle-wait RAM: i_read=1, i_address=0xBFC00000.
  - Next cycle: grant=01, address=0xBFC00000, read=1.
  - i_waitrequest falls one cycle later; i_readdata equals RAM word.
  - Then grant=00.
- Simultaneous i_read and d_write (d_address=0x1000, d_writedata=0xDEADBEEF, byteenable=4'b0011), fixed priority:
  - D granted first; RAM word 0x1000 low half=0xBEEF.
  - Then GNT_I directly, with no IDLE cycle between.
- Same as previous with MIPS_ARB_ROUND_ROBIN_EN after reset: I granted first, then D. A second tie grants D first.
- WAIT_LIMIT=8, RAM holds waitrequest=1 indefinitely after a d_read: bus_error rises after exactly 8 stalled GNT_D cycles and stays 1.
- rst_n pulsed low mid-GNT_D with waitrequest=1:
  - read/write=0 and grant=00 asynchronously.
  - Both waitrequests=1; bus_error=0.
  - After release, a new fetch completes normally.
- D asserts d_read and d_write together (address 0x20): write=1, read=0 at slave; memory updated, no read performed.
